// File: rtl/pwm_deadtime.sv
// pwm_deadtime: complementary gate drive with programmable dead bands, enable gating and latched fault.
module pwm_deadtime #(
  parameter int DT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_pwm,
  input  logic            i_en,
  input  logic [DT_W-1:0] i_dt_rise,
  input  logic [DT_W-1:0] i_dt_fall,
  input  logic            i_fault,
  input  logic            i_fault_clr,
  output logic            o_hi,
  output logic            o_lo,
  output logic            o_dead,
  output logic            o_fault
);
  typedef enum logic [2:0] {IDLE, LO_ON, DT_RISE, HI_ON, DT_FALL} state_t;
  state_t state_q, state_d;
  logic [DT_W-1:0] cnt_q, cnt_d;
  logic fault_q, fault_d;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end
  // a pwm reversal inside a dead band aborts it: the opposite switch never turned on
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fault_d = i_fault | (fault_q & ~i_fault_clr);
    if (fault_q | i_fault | ~i_en) state_d = IDLE;
    else begin
      case (state_q)
        IDLE, LO_ON: begin
          state_d = i_pwm ? DT_RISE : LO_ON;
          cnt_d   = i_pwm ? i_dt_rise : cnt_q;
        end
        DT_RISE: begin
          state_d = !i_pwm ? LO_ON : (cnt_q == '0) ? HI_ON : DT_RISE;
          cnt_d   = (i_pwm && cnt_q != '0) ? cnt_q - DT_W'(1) : cnt_q;
        end
        HI_ON: begin
          state_d = i_pwm ? HI_ON : DT_FALL;
          cnt_d   = i_pwm ? cnt_q : i_dt_fall;
        end
        DT_FALL: begin
          state_d = i_pwm ? HI_ON : (cnt_q == '0) ? LO_ON : DT_FALL;
          cnt_d   = (!i_pwm && cnt_q != '0) ? cnt_q - DT_W'(1) : cnt_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  assign o_hi    = (state_q == HI_ON);
  assign o_lo    = (state_q == LO_ON);
  assign o_dead  = (state_q == DT_RISE) || (state_q == DT_FALL);
  assign o_fault = fault_q;
endmodule

// File: tb/tb_pwm_deadtime.sv
// tb_pwm_deadtime: directed per-cycle vectors queued as expected {hi,lo,dead,fault}; a monitor pops and compares each cycle.
module tb_pwm_deadtime;
  logic clk = 1'b0, rst = 1'b0, i_pwm = 1'b0, i_en = 1'b0, i_fault = 1'b0, i_fault_clr = 1'b0;
  logic [7:0] i_dt_rise = '0, i_dt_fall = '0;
  logic o_hi, o_lo, o_dead, o_fault;
  int total = 0, bad = 0, cyc_n = 0;
  typedef struct packed {logic [3:0] v; logic [3:0] m;} exp_t;
  exp_t q[$];

  pwm_deadtime #(.DT_W(8)) dut (
    .clk(clk), .rst(rst), .i_pwm(i_pwm), .i_en(i_en),
    .i_dt_rise(i_dt_rise), .i_dt_fall(i_dt_fall),
    .i_fault(i_fault), .i_fault_clr(i_fault_clr),
    .o_hi(o_hi), .o_lo(o_lo), .o_dead(o_dead), .o_fault(o_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp, input logic [3:0] m);
    total++;
    if ((act & m) !== (exp & m)) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%b expected=%b mask=%b", nm, cyc_n, act, exp, m);
    end
  endtask

  // monitor: every edge presents a new output word
  always @(posedge clk) begin
    #1;
    cyc_n++;
    if (rst) chk("hi_lo_exclusive", {3'b000, o_hi & o_lo}, 4'b0000, 4'b0001);
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.m != 4'b0000) chk("outputs", {o_hi, o_lo, o_dead, o_fault}, e.v, e.m);
    end
  end

  // apply inputs for n edges; exp is the output word expected after each of them
  task automatic run(input int n, input logic pwm, input logic en, input logic f, input logic clr,
                     input logic [3:0] exp, input logic [3:0] m = 4'hf);
    for (int k = 0; k < n; k++) begin
      i_pwm = pwm; i_en = en; i_fault = f; i_fault_clr = clr;
      q.push_back('{v: exp, m: m});
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    @(posedge clk);
    #2;
    chk("reset_outputs", {o_hi, o_lo, o_dead, o_fault}, 4'b0000, 4'hf);
    rst = 1'b1;
    i_dt_rise = 8'd3; i_dt_fall = 8'd0;
    run(9, 0, 1, 0, 0, 4'b0100);
    run(4, 1, 1, 0, 0, 4'b0010);
    run(16, 1, 1, 0, 0, 4'b1000);
    run(1, 0, 1, 0, 0, 4'b0010);
    run(3, 0, 1, 0, 0, 4'b0100);
    // glitch swallowing and minimum-width high pulse
    i_dt_rise = 8'd5;
    run(3, 1, 1, 0, 0, 4'b0010);
    run(3, 0, 1, 0, 0, 4'b0100);
    run(6, 1, 1, 0, 0, 4'b0010);
    run(1, 1, 1, 0, 0, 4'b1000);
    run(1, 0, 1, 0, 0, 4'b0010);
    run(3, 0, 1, 0, 0, 4'b0100);
    // fault latch
    i_dt_rise = 8'd1;
    run(2, 1, 1, 0, 0, 4'b0010);
    run(3, 1, 1, 0, 0, 4'b1000);
    run(1, 1, 1, 1, 0, 4'b0001);
    run(2, 0, 1, 0, 0, 4'b0001);
    run(2, 1, 1, 0, 0, 4'b0001);
    run(1, 0, 1, 0, 0, 4'b0001);
    run(1, 0, 1, 0, 1, 4'b0000);
    run(2, 0, 1, 0, 0, 4'b0100);
    run(1, 0, 1, 1, 1, 4'b0001);
    run(2, 0, 1, 0, 0, 4'b0001);
    run(1, 0, 1, 0, 1, 4'b0000);
    run(1, 0, 1, 0, 0, 4'b0100);
    // dead time changed mid band only affects the next band
    i_dt_rise = 8'd10;
    run(2, 1, 1, 0, 0, 4'b0010);
    i_dt_rise = 8'd1;
    run(9, 1, 1, 0, 0, 4'b0010);
    run(1, 1, 1, 0, 0, 4'b1000);
    run(1, 0, 1, 0, 0, 4'b0010);
    run(1, 0, 1, 0, 0, 4'b0100);
    run(2, 1, 1, 0, 0, 4'b0010);
    run(1, 1, 1, 0, 0, 4'b1000);
    // enable drop during HI_ON and mid dead band
    run(1, 1, 0, 0, 0, 4'b0000);
    run(2, 1, 1, 0, 0, 4'b0010);
    run(1, 1, 1, 0, 0, 4'b1000);
    i_dt_fall = 8'd3;
    run(2, 0, 1, 0, 0, 4'b0010);
    run(1, 0, 0, 0, 0, 4'b0000);
    run(1, 0, 1, 0, 0, 4'b0100);
    // asynchronous reset in the middle of DT_FALL
    run(2, 1, 1, 0, 0, 4'b0010);
    run(1, 1, 1, 0, 0, 4'b1000);
    run(2, 0, 1, 0, 0, 4'b0010);
    rst = 1'b0;
    #1;
    chk("async_reset", {o_hi, o_lo, o_dead, o_fault}, 4'b0000, 4'hf);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #2;
    run(1, 0, 1, 0, 0, 4'b0100);
    // random pwm edges: only exclusivity is checked
    for (int k = 0; k < 1000; k++) begin
      i_dt_rise = 8'($urandom_range(0, 3));
      i_dt_fall = 8'($urandom_range(0, 3));
      run(1, 1'($urandom_range(0, 1)), 1, 0, 0, 4'b0000, 4'b0000);
    end
    run(1, 0, 0, 0, 0, 4'b0000);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain queue_left=%0d expected=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pwm_deadtime.md
Name: pwm_deadtime

Overview:
- Downstream stage of the PWM generator. Consumes its single-ended PWM output and drives a complementary high-side/low-side gate pair.
- Inserts programmable dead bands so the two outputs are never high together.
- Adds enable gating and a latched fault shutdown.
- All logic is on one clock domain with the PWM generator.

Parameters:
DT_W, 8, width of the dead-time programming inputs and of the internal dead-time counter

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-low reset
i_pwm  input  1  PWM command from the upstream generator, same clock domain
i_en  input  1  output enable; 0 forces both outputs low
i_dt_rise  input  DT_W  dead time inserted before o_hi asserts (cycles minus 1)
i_dt_fall  input  DT_W  dead time inserted before o_lo asserts (cycles minus 1)
i_fault  input  1  fault request, level sensitive, sampled on clk
i_fault_clr  input  1  clears the fault latch
o_hi  output  1  high-side gate drive, registered
o_lo  output  1  low-side gate drive, registered
o_dead  output  1  high while in a dead band, registered
o_fault  output  1  sticky fault latch, registered

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0, fault latch=0, all outputs 0. On release, leave IDLE only on the first rising clk edge after rst=1.
- Outputs decode directly from the state register, with no combinational path from any input:
  - o_hi=(HI_ON)
  - o_lo=(LO_ON)
  - o_dead=(DT_RISE|DT_FALL)
  - o_hi and o_lo are never both 1.
- States: IDLE, LO_ON, DT_RISE, HI_ON, DT_FALL.
- Priority each edge: fault latched or i_fault=1 > i_en=0 > normal transitions. Either override sends the block to IDLE next edge.
- IDLE (i_en=1, no fault):
  - i_pwm=0 -> LO_ON.
  - i_pwm=1 -> DT_RISE, counter<=i_dt_rise.
- LO_ON:
  - i_pwm=1 -> DT_RISE, counter<=i_dt_rise.
  - Otherwise stay.
- DT_RISE:
  - i_pwm=0 -> LO_ON. This swallows a glitch shorter than the dead band; no dead band is needed because o_hi never asserted.
  - counter==0 and i_pwm=1 -> HI_ON.
  - Otherwise counter<=counter-1.
- HI_ON:
  - i_pwm=0 -> DT_FALL, counter<=i_dt_fall.
  - Otherwise stay.
- DT_FALL (mirror of DT_RISE):
  - i_pwm=1 -> HI_ON.
  - counter==0 and i_pwm=0 -> LO_ON.
  - Otherwise decrement.
- Timing:
  - Edge latency: o_lo falls 1 clk after the edge at which i_pwm=1 is first sampled.
  - Dead band: exactly i_dt_rise+1 cycles (i_dt_fall+1 for the falling transition). A value of 0 gives a 1-cycle dead band; a value of 2^DT_W-1 gives 2^DT_W cycles.
- Dead-time inputs are sampled only at counter load. Changes during a dead band take effect at the next transition.
- The counter never wraps; it only decrements from a non-zero value.
- Fault latch:
  - Sets on any edge with i_fault=1.
  - Clears on an edge with i_fault_clr=1 and i_fault=0. When both are 1, set wins.
  - o_fault follows the latch 1 clk after the sampling edge; o_hi/o_lo drop on that same edge.
  - After clear, the block resumes from IDLE via the normal rules.
- Enable: i_en 1->0 mid dead band or mid pulse -> IDLE next edge, regardless of counter state.

Test Plan:
- Reset, then i_en=1, i_pwm=0, dt_rise=3 -> o_lo=1 on the 1st edge. Raise i_pwm at edge 10 -> o_lo=0 after edge 10, o_dead=1 for 4 cycles, o_hi=1 after edge 14.
- i_pwm high for 20 cycles then low, dt_fall=0 -> o_hi falls 1 clk after, o_dead=1 for exactly 1 cycle, then o_lo=1. Check o_hi&o_lo never 1 across 1000 random PWM edges.
- dt_rise=5, i_pwm pulse 3 cycles wide -> o_hi never asserts, o_lo returns 1 with no extra dead band. i_pwm pulse 7 wide -> o_hi high for 1 cycle.
- i_fault pulse of 1 cycle during HI_ON -> o_hi=0 and o_fault=1 next edge, both outputs stay 0 with i_pwm toggling. i_fault_clr=1 -> o_fault=0 next edge, o_lo/o_hi resume. i_fault and i_fault_clr together -> o_fault stays 1.
- Change i_dt_rise from 10 to 1 at cycle 3 of a dead band -> the current band still lasts 11 cycles; the next band lasts 2.
- Assert rst=0 asynchronously mid DT_FALL (between edges) -> all outputs 0 immediately. i_en=0 during HI_ON -> both outputs 0 next edge.
